pc_ctrl: RTL and testbench

Next-PC controller for the fetch stage: owns the PC register, arbitrates redirect requests from decode (branch/jump), the exception unit (exception/interrupt entry, ERET) and the hazard unit (stall), and produces the PC and PC+4 consumed by instruction memory. A three-state FSM sequences exception entry, handler execution and return, capturing EPC and driving the pipeline flush.

---
 rtl/pc_ctrl_pkg.sv | 33 +++
 rtl/pc_ctrl_npc_mux.sv | 64 ++++++
 rtl/pc_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pc_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared definitions for the fetch-stage next-PC controller.
//   - Address constants: reset PC, exception vector, instruction memory window.
//   - Controller state encoding (RUN / ENTRY / HANDLER).
//   - Next-PC source select encoding used by the npc mux.
//   - Helper function for the fetch address alignment test.
package pc_ctrl_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT   = 32'h0000_4ffc;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_HANDLER = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SRC_VEC  = 3'd0,
    SRC_EPC  = 3'd1,
    SRC_HOLD = 3'd2,
    SRC_BR   = 3'd3,
    SRC_J    = 3'd4,
    SRC_SEQ  = 3'd5
  } npc_src_e;

  // Word fetches must be 4-byte aligned.
  function automatic logic addr_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_ctrl_npc_mux.sv
// pc_ctrl_npc_mux: combinational priority select of the next fetch PC.
// Ports:
//   take      in  1   exception/interrupt entry (highest priority)
//   eret_ok   in  1   ERET accepted (only meaningful in handler)
//   stall     in  1   hold current PC
//   br_taken  in  1   branch taken, beats j_en when both are set
//   j_en      in  1   jump
//   pc        in  32  current PC
//   pc_add4   in  32  sequential PC
//   epc       in  32  saved exception PC
//   br_target in  32  branch target
//   j_target  in  32  jump target
//   npc       out 32  selected next PC
module pc_ctrl_npc_mux
  import pc_ctrl_pkg::*;
(
  input  logic        take,
  input  logic        eret_ok,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        j_en,
  input  logic [31:0] pc,
  input  logic [31:0] pc_add4,
  input  logic [31:0] epc,
  input  logic [31:0] br_target,
  input  logic [31:0] j_target,
  output logic [31:0] npc
);

  npc_src_e src_s;

  // Priority encode the redirect enables into a single source select.
  always_comb begin
    src_s = SRC_SEQ;
    if (take) begin
      src_s = SRC_VEC;
    end else if (eret_ok) begin
      src_s = SRC_EPC;
    end else if (stall) begin
      src_s = SRC_HOLD;
    end else if (br_taken) begin
      src_s = SRC_BR;
    end else if (j_en) begin
      src_s = SRC_J;
    end else begin
      src_s = SRC_SEQ;
    end
  end

  // Route the selected source onto the next-PC bus.
  always_comb begin
    npc = pc_add4;
    case (src_s)
      SRC_VEC:  npc = EXC_VECTOR;
      SRC_EPC:  npc = epc;
      SRC_HOLD: npc = pc;
      SRC_BR:   npc = br_target;
      SRC_J:    npc = j_target;
      SRC_SEQ:  npc = pc_add4;
      default:  npc = pc_add4;
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: next-PC controller for the fetch stage. Owns the PC and EPC
// registers and a RUN/ENTRY/HANDLER FSM that sequences exception entry,
// handler execution and ERET return.
// Optional feature: define PC_RANGE_CHECK_EN to also flag fetch addresses
// outside [IM_BASE, IM_LIMIT] on pc_exp.
// Ports:
//   clk       in  1   system clock, rising edge
//   reset     in  1   asynchronous active-low reset
//   stall     in  1   hold PC
//   br_taken  in  1   branch taken, br_target in 32
//   j_en      in  1   jump, j_target in 32
//   exc_req   in  1   synchronous exception
//   int_req   in  1   level interrupt request (masked while exl)
//   exc_pc    in  32  victim PC captured into epc on entry from RUN
//   eret      in  1   return from handler
//   pc        out 32  current fetch PC (registered)
//   pc_add4   out 32  pc + 4, wrap-around
//   pc_exp    out 1   fetch address exception for current pc
//   epc       out 32  saved exception PC
//   exl       out 1   handler active
//   flush     out 1   squash F/D/E, high for the single ENTRY cycle
module pc_ctrl
  import pc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        j_en,
  input  logic [31:0] j_target,
  input  logic        exc_req,
  input  logic        int_req,
  input  logic [31:0] exc_pc,
  input  logic        eret,
  output logic [31:0] pc,
  output logic [31:0] pc_add4,
  output logic        pc_exp,
  output logic [31:0] epc,
  output logic        exl,
  output logic        flush
);

  state_e      state_r;
  state_e      state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] epc_r;
  logic [31:0] npc_s;
  logic        take_s;
  logic        eret_ok_s;
  logic        capture_s;
  logic        exl_s;
  logic        flush_s;
  logic        pc_exp_s;

  // Interrupts are masked only while the handler runs; exceptions never are.
  assign take_s    = exc_req | (int_req & ~exl_s);
  assign eret_ok_s = eret & (state_r == ST_HANDLER);
  // EPC is written only on the first entry; nested entries keep the original.
  assign capture_s = take_s & (state_r == ST_RUN);

  pc_ctrl_npc_mux u_npc_mux (
    .take      (take_s),
    .eret_ok   (eret_ok_s),
    .stall     (stall),
    .br_taken  (br_taken),
    .j_en      (j_en),
    .pc        (pc_r),
    .pc_add4   (pc_add4),
    .epc       (epc_r),
    .br_target (br_target),
    .j_target  (j_target),
    .npc       (npc_s)
  );

  // State, PC and EPC registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
      pc_r    <= RESET_PC;
      epc_r   <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= npc_s;
      if (capture_s) begin
        epc_r <= exc_pc;
      end
    end
  end

  // Next-state logic for the exception sequencing FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (take_s) begin
          state_nxt_s = ST_ENTRY;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_ENTRY: begin
        if (exc_req) begin
          state_nxt_s = ST_ENTRY;
        end else begin
          state_nxt_s = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        if (exc_req) begin
          state_nxt_s = ST_ENTRY;
        end else if (eret) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HANDLER;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // Output decode straight from the state register (no input paths).
  always_comb begin
    exl_s   = 1'b0;
    flush_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        exl_s   = 1'b0;
        flush_s = 1'b0;
      end
      ST_ENTRY: begin
        exl_s   = 1'b0;
        flush_s = 1'b1;
      end
      ST_HANDLER: begin
        exl_s   = 1'b1;
        flush_s = 1'b0;
      end
      default: begin
        exl_s   = 1'b0;
        flush_s = 1'b0;
      end
    endcase
  end

  // Fetch address exception flag, derived only from the PC register.
  always_comb begin
    pc_exp_s = addr_misaligned(pc_r);
`ifdef PC_RANGE_CHECK_EN
    if ((pc_r < IM_BASE) || (pc_r > IM_LIMIT)) begin
      pc_exp_s = 1'b1;
    end else begin
      pc_exp_s = addr_misaligned(pc_r);
    end
`endif
  end

  assign pc      = pc_r;
  assign pc_add4 = pc_r + 32'd4;
  assign pc_exp  = pc_exp_s;
  assign epc     = epc_r;
  assign exl     = exl_s;
  assign flush   = flush_s;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed test-plan steps followed by randomized traffic,
// checked against a behavioural model of the controller rules.
module tb_pc_ctrl;

  localparam logic [31:0] T_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] T_VEC      = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_taken, j_en, exc_req, int_req, eret;
  logic [31:0] br_target, j_target, exc_pc;
  logic [31:0] pc, pc_add4, epc;
  logic        pc_exp, exl, flush;

  int checks   = 0;
  int failures = 0;

  // model: program counter, saved pc and mode flags
  logic [31:0] m_pc, m_epc;
  bit          m_entering, m_in_handler;

  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .j_en(j_en), .j_target(j_target),
    .exc_req(exc_req), .int_req(int_req), .exc_pc(exc_pc), .eret(eret),
    .pc(pc), .pc_add4(pc_add4), .pc_exp(pc_exp),
    .epc(epc), .exl(exl), .flush(flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_fault(input logic [31:0] a);
    logic f;
    f = (a % 32'd4) != 32'd0;
`ifdef PC_RANGE_CHECK_EN
    f = f || (a < 32'h0000_3000) || (a > 32'h0000_4ffc);
`endif
    return f;
  endfunction

  function automatic void m_reset();
    m_pc = T_RESET_PC; m_epc = 32'd0; m_entering = 1'b0; m_in_handler = 1'b0;
  endfunction

  // Apply one clock of the controller rules to the model.
  function automatic void m_step();
    bit take, ret;
    logic [31:0] nxt;
    take = exc_req || (int_req && !m_in_handler);
    ret  = eret && m_in_handler;
    if (take)          nxt = T_VEC;
    else if (ret)      nxt = m_epc;
    else if (stall)    nxt = m_pc;
    else if (br_taken) nxt = br_target;
    else if (j_en)     nxt = j_target;
    else               nxt = m_pc + 32'd4;
    if (m_entering) begin
      m_entering   = exc_req;
      m_in_handler = !exc_req;
    end else if (m_in_handler) begin
      if (exc_req) begin
        m_entering = 1'b1; m_in_handler = 1'b0;
      end else if (eret) begin
        m_in_handler = 1'b0;
      end
    end else if (take) begin
      m_entering = 1'b1;
      m_epc      = exc_pc;
    end
    m_pc = nxt;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".pc"},      pc,              m_pc);
    chk({tag, ".pc_add4"}, pc_add4,         m_pc + 32'd4);
    chk({tag, ".pc_exp"},  {31'd0, pc_exp}, {31'd0, exp_fault(m_pc)});
    chk({tag, ".epc"},     epc,             m_epc);
    chk({tag, ".exl"},     {31'd0, exl},    {31'd0, m_in_handler});
    chk({tag, ".flush"},   {31'd0, flush},  {31'd0, m_entering});
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    m_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    stall = 1'b0; br_taken = 1'b0; j_en = 1'b0; exc_req = 1'b0;
    int_req = 1'b0; eret = 1'b0;
    br_target = 32'd0; j_target = 32'd0; exc_pc = 32'd0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    m_reset();
    #12;
    check_all("in_reset");
    chk("rst_pc", pc, 32'h0000_3000);
    #6 reset = 1'b1;

    // sequential fetch after reset
    chk("seq0_pc", pc, 32'h0000_3000);
    chk("seq0_add4", pc_add4, 32'h0000_3004);
    tick("seq1"); chk("seq1_pc", pc, 32'h0000_3004);
    tick("seq2"); chk("seq2_pc", pc, 32'h0000_3008);
    chk("seq2_add4", pc_add4, 32'h0000_300c);

    // stall holds a pending branch
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h0000_3100;
    tick("stall1"); chk("stall1_pc", pc, 32'h0000_3008);
    tick("stall2"); chk("stall2_pc", pc, 32'h0000_3008);
    stall = 1'b0;
    tick("br"); chk("br_pc", pc, 32'h0000_3100);
    br_taken = 1'b0;

    // exception entry overrides stall
    exc_req = 1'b1; exc_pc = 32'h0000_3010; stall = 1'b1;
    tick("exc");
    chk("exc_pc", pc, 32'h0000_4180);
    chk("exc_flush", {31'd0, flush}, 32'd1);
    chk("exc_epc", epc, 32'h0000_3010);
    exc_req = 1'b0; stall = 1'b0;
    tick("hnd"); chk("hnd_exl", {31'd0, exl}, 32'd1);
    chk("hnd_flush", {31'd0, flush}, 32'd0);

    // interrupt masked in handler, eret returns, held int re-enters
    int_req = 1'b1;
    tick("int_mask"); chk("int_mask_pc", pc, 32'h0000_4188);
    eret = 1'b1;
    tick("eret"); chk("eret_pc", pc, 32'h0000_3010);
    chk("eret_exl", {31'd0, exl}, 32'd0);
    eret = 1'b0;
    tick("int_take"); chk("int_take_pc", pc, 32'h0000_4180);
    int_req = 1'b0;
    tick("hnd2");

    // nested exception keeps epc
    exc_req = 1'b1; exc_pc = 32'h0000_4188;
    tick("nest"); chk("nest_pc", pc, 32'h0000_4180);
    chk("nest_epc", epc, 32'h0000_3010);
    exc_req = 1'b0;
    tick("nest_hnd");
    eret = 1'b1;
    tick("nest_ret"); chk("nest_ret_pc", pc, 32'h0000_3010);

    // eret in RUN is ignored
    tick("eret_run"); chk("eret_run_pc", pc, 32'h0000_3014);
    eret = 1'b0;

    // misaligned branch, br beats jump, out-of-window jump, wrap
    br_taken = 1'b1; br_target = 32'h0000_3002; j_en = 1'b1; j_target = 32'h0000_3200;
    tick("mis"); chk("mis_pc", pc, 32'h0000_3002);
    chk("mis_exp", {31'd0, pc_exp}, 32'd1);
    br_taken = 1'b0; j_target = 32'h0000_5000;
    tick("range"); chk("range_pc", pc, 32'h0000_5000);
`ifdef PC_RANGE_CHECK_EN
    chk("range_exp", {31'd0, pc_exp}, 32'd1);
`else
    chk("range_exp", {31'd0, pc_exp}, 32'd0);
`endif
    j_target = 32'hffff_fffc;
    tick("wrap"); chk("wrap_add4", pc_add4, 32'h0000_0000);
    idle_inputs();

    // randomized traffic, with one asynchronous reset in the middle
    for (int i = 0; i < 600; i++) begin
      stall     = ($urandom_range(99) < 20);
      br_taken  = ($urandom_range(99) < 25);
      j_en      = ($urandom_range(99) < 20);
      exc_req   = ($urandom_range(99) < 6);
      int_req   = ($urandom_range(99) < 10);
      eret      = ($urandom_range(99) < 15);
      br_target = 32'h0000_3000 + ($urandom_range(1023) << 2) + (($urandom_range(9) == 0) ? 32'd2 : 32'd0);
      j_target  = $urandom & 32'hffff_fffc;
      exc_pc    = $urandom;
      tick("rnd");
      if (i == 300) begin
        #2 reset = 1'b0;
        #1;
        m_reset();
        check_all("async_rst");
        #1 reset = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
